wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the 5-stage pipeline (fetch, decode, alu, tlblookup, write-back). It registers the result, destination address and write enable produced by the TLB-lookup stage. It drives them to decode's register-file write port (`dWB` / `writeAddrWB` / `writeEnableWB`). It also supplies same-cycle operand forwarding to decode and keeps a count of retired register writes.

## Interface
Parameters:
- `DATA_W`, 16, datapath width.
- `ADDR_W`, 3, register-address width (8 registers).
- `CNT_W`, 16, retire-counter width.

Ports:
- `clk`  in  1  single pipeline clock, rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising `clk`.
- `enable_wb`  in  1  stage advance; 0 = stall (hold).
- `tlblookup_result`  in  DATA_W  result from TLB-lookup stage.
- `destReg_addr_input`  in  ADDR_W  destination register from TLB-lookup stage.
- `we_input`  in  1  write request from TLB-lookup stage.
- `srcA_addr`  in  ADDR_W  decode operand-A register address.
- `srcB_addr`  in  ADDR_W  decode operand-B register address.
- `dWB`  out  DATA_W  write data to decode register file.
- `writeAddrWB`  out  ADDR_W  write address to decode register file.
- `writeEnableWB`  out  1  write strobe to decode register file.
- `fwdA_hit`  out  1  operand A must take `fwd_data`.
- `fwdB_hit`  out  1  operand B must take `fwd_data`.
- `fwd_data`  out  DATA_W  forwarded value (equals `dWB`).
- `retired_count`  out  CNT_W  number of committed register writes.

## Operation
- Pipeline register: `data_r`, `addr_r`, `valid_r`.
- Rising `clk` with `reset`=1: `data_r`=0, `addr_r`=0, `valid_r`=0, `retired_count`=0. Reset wins over every other input.
- Rising `clk` with `enable_wb`=1: `data_r`<=`tlblookup_result`, `addr_r`<=`destReg_addr_input`, `valid_r`<=`we_input`.
- Rising `clk` with `enable_wb`=0: `data_r` and `addr_r` hold. `valid_r`<=0, because the held write was already performed once and must not be repeated or recounted.
- Outputs: `dWB`=`data_r`, `writeAddrWB`=`addr_r`, `writeEnableWB`=`valid_r`.
- Forwarding (combinational):
  - `fwdA_hit` = `valid_r` && (`srcA_addr`==`addr_r`).
  - `fwdB_hit` = `valid_r` && (`srcB_addr`==`addr_r`).
  - `fwd_data`=`data_r`.
  - Both hits may assert together when A and B name the same register.
- Retire counter: on each rising edge where `reset`=0 and `writeEnableWB`=1, `retired_count` increments by 1 modulo 2^CNT_W. `0xFFFF` wraps to `0x0000`.
- A write with `we_input`=0 passes through with `writeEnableWB`=0. No forwarding and no count.

## Timing
- Latency: inputs sampled at edge N appear on all outputs after edge N, i.e. valid during cycle N+1.
- Decode's register file commits `dWB` at the edge ending cycle N+1. Forwarding covers the read-during-write in cycle N+1; no further history is needed.
- `enable_wb` held low for k cycles: `writeEnableWB` is high for at most the first cycle only (the original capture), then low. `dWB`/`writeAddrWB` stay stable for the whole stall.
- Reset asserted mid-stream: outputs are 0 from the cycle after the reset edge. Any in-flight write is dropped, not committed.
- `enable_wb`=1 with `reset`=1: reset takes priority.
- Forwarding outputs follow `srcA_addr`/`srcB_addr` combinationally within the same cycle.

## Configuration
- `WB_FORWARD_EN` defined: forwarding logic as described above.
- `WB_FORWARD_EN` undefined: `fwdA_hit`=0 and `fwdB_hit`=0 constantly, and `fwd_data`=0. Ports remain present. Decode then relies solely on register-file read-after-write ordering. The pipeline register and retire counter are unaffected.

## Test plan
- Reset, then `enable_wb`=1, `tlblookup_result`=0x1234, `destReg_addr_input`=5, `we_input`=1 for one cycle -> next cycle `dWB`=0x1234, `writeAddrWB`=5, `writeEnableWB`=1; following cycle (`we_input`=0) `writeEnableWB`=0; `retired_count`=1.
- Capture write 0xBEEF to r3, then hold `enable_wb`=0 for 4 cycles -> `writeEnableWB` high for exactly 1 cycle, `dWB`=0xBEEF and `writeAddrWB`=3 stable for all 5 cycles, `retired_count` +1 only.
- With write of 0x00AA to r2 valid, drive `srcA_addr`=2, `srcB_addr`=2 -> `fwdA_hit`=1, `fwdB_hit`=1, `fwd_data`=0x00AA; drive `srcB_addr`=4 -> `fwdB_hit`=0; with `we_input`=0 captured -> both hits 0.
- Preload counter to 0xFFFE via 65534 writes (or force), issue 3 writes -> `retired_count` sequence 0xFFFF, 0x0000, 0x0001.
- Assert `reset` while `enable_wb`=1 and `we_input`=1 carrying 0x5555 to r7 -> next cycle `writeEnableWB`=0, `dWB`=0, `writeAddrWB`=0, `retired_count`=0.
- Build without `WB_FORWARD_EN`, repeat the forwarding scenario -> `fwdA_hit`=`fwdB_hit`=0; write-back outputs identical to the forwarding build.

Source files
------------

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Write-back stage of the 5-stage pipeline. Registers the
//               TLB-lookup result, destination address and write enable, and
//               drives them to the decode register-file write port. Supplies
//               same-cycle operand forwarding and counts retired writes.
//               Optional feature macro: WB_FORWARD_EN (forwarding logic).
//               When WB_FORWARD_EN is undefined, the forwarding outputs are
//               tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_wb,
  input  logic [DATA_W-1:0] tlblookup_result,
  input  logic [ADDR_W-1:0] destReg_addr_input,
  input  logic              we_input,
  input  logic [ADDR_W-1:0] srcA_addr,
  input  logic [ADDR_W-1:0] srcB_addr,
  output logic [DATA_W-1:0] dWB,
  output logic [ADDR_W-1:0] writeAddrWB,
  output logic              writeEnableWB,
  output logic              fwdA_hit,
  output logic              fwdB_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] data_r;
  logic [ADDR_W-1:0] addr_r;
  logic              valid_r;
  logic [CNT_W-1:0]  count_r;

  // Pipeline register; a stall keeps data/address but drops the strobe so
  // the write that was already performed is not repeated.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r  <= '0;
      addr_r  <= '0;
      valid_r <= 1'b0;
    end else if (enable_wb) begin
      data_r  <= tlblookup_result;
      addr_r  <= destReg_addr_input;
      valid_r <= we_input;
    end else begin
      valid_r <= 1'b0;
    end
  end

  // Retire counter: a write counts at the edge where decode commits it.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (valid_r) begin
      count_r <= count_r + CNT_ONE;
    end
  end

  assign dWB           = data_r;
  assign writeAddrWB   = addr_r;
  assign writeEnableWB = valid_r;
  assign retired_count = count_r;

`ifdef WB_FORWARD_EN
  // Forwarding covers the read-during-write in the cycle the result is held.
  always_comb begin
    fwdA_hit = valid_r && (srcA_addr == addr_r);
    fwdB_hit = valid_r && (srcB_addr == addr_r);
    fwd_data = data_r;
  end
`else
  // Forwarding disabled: decode relies on register-file write-before-read.
  logic unused_src;
  assign unused_src = ^{srcA_addr, srcB_addr};

  always_comb begin
    fwdA_hit = 1'b0;
    fwdB_hit = 1'b0;
    fwd_data = '0;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Self-checking bench for wb_stage. A reference model computes
//               the expected register state at each driven edge and pushes it
//               to a scoreboard queue; each test pops and compares after the
//               edge. Forwarding expectations follow WB_FORWARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_wb;
  logic [15:0] tlblookup_result;
  logic [2:0]  destReg_addr_input;
  logic        we_input;
  logic [2:0]  srcA_addr;
  logic [2:0]  srcB_addr;
  logic [15:0] dWB;
  logic [2:0]  writeAddrWB;
  logic        writeEnableWB;
  logic        fwdA_hit;
  logic        fwdB_hit;
  logic [15:0] fwd_data;
  logic [15:0] retired_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  addr;
    logic        we;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  logic [15:0] m_data = '0;
  logic [2:0]  m_addr = '0;
  logic        m_valid = 1'b0;
  logic [15:0] m_cnt = '0;

`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  wb_stage #(.DATA_W(16), .ADDR_W(3), .CNT_W(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .enable_wb          (enable_wb),
    .tlblookup_result   (tlblookup_result),
    .destReg_addr_input (destReg_addr_input),
    .we_input           (we_input),
    .srcA_addr          (srcA_addr),
    .srcB_addr          (srcB_addr),
    .dWB                (dWB),
    .writeAddrWB        (writeAddrWB),
    .writeEnableWB      (writeEnableWB),
    .fwdA_hit           (fwdA_hit),
    .fwdB_hit           (fwdB_hit),
    .fwd_data           (fwd_data),
    .retired_count      (retired_count)
  );

  // Drive one cycle of stimulus, push the model's post-edge state, advance.
  task automatic drive(input logic rst, input logic en, input logic [15:0] d,
                       input logic [2:0] a, input logic we);
    reset              = rst;
    enable_wb          = en;
    tlblookup_result   = d;
    destReg_addr_input = a;
    we_input           = we;
    if (rst) begin
      m_data = '0; m_addr = '0; m_valid = 1'b0; m_cnt = '0;
    end else begin
      if (m_valid) m_cnt = m_cnt + 16'd1;
      if (en) begin
        m_data = d; m_addr = a; m_valid = we;
      end else begin
        m_valid = 1'b0;
      end
    end
    sb.push_back('{data: m_data, addr: m_addr, we: m_valid, cnt: m_cnt});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 16'h5555, 3'd7, 1'b1);
    e = sb.pop_front();
    checks++;
    if ({dWB, writeAddrWB, writeEnableWB, retired_count} !== {16'h0, 3'd0, 1'b0, 16'h0} ||
        {dWB, writeAddrWB, writeEnableWB, retired_count} !== {e.data, e.addr, e.we, e.cnt}) begin
      errors++;
      $display("FAIL reset_state: got d=%h a=%0d we=%b cnt=%h want d=0 a=0 we=0 cnt=0",
               dWB, writeAddrWB, writeEnableWB, retired_count);
    end
    checks++;
    if ({fwdA_hit, fwdB_hit, fwd_data} !== {1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_fwd: got hA=%b hB=%b fd=%h want 0 0 0", fwdA_hit, fwdB_hit, fwd_data);
    end
  endtask

  task automatic test_basic();
    drive(1'b0, 1'b1, 16'h1234, 3'd5, 1'b1);
    e = sb.pop_front();
    checks++;
    if ({dWB, writeAddrWB, writeEnableWB} !== {16'h1234, 3'd5, 1'b1} ||
        {dWB, writeAddrWB, writeEnableWB, retired_count} !== {e.data, e.addr, e.we, e.cnt}) begin
      errors++;
      $display("FAIL basic_capture: got d=%h a=%0d we=%b cnt=%h want d=%h a=%0d we=%b cnt=%h",
               dWB, writeAddrWB, writeEnableWB, retired_count, e.data, e.addr, e.we, e.cnt);
    end
    drive(1'b0, 1'b1, 16'h0000, 3'd0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (writeEnableWB !== 1'b0 || retired_count !== 16'd1 ||
        {dWB, writeAddrWB, writeEnableWB, retired_count} !== {e.data, e.addr, e.we, e.cnt}) begin
      errors++;
      $display("FAIL basic_nowrite: got d=%h a=%0d we=%b cnt=%h want d=%h a=%0d we=0 cnt=1",
               dWB, writeAddrWB, writeEnableWB, retired_count, e.data, e.addr);
    end
  endtask

  task automatic test_stall();
    logic [15:0] cnt0;
    drive(1'b0, 1'b1, 16'hBEEF, 3'd3, 1'b1);
    e = sb.pop_front();
    cnt0 = e.cnt;
    checks++;
    if ({dWB, writeAddrWB, writeEnableWB, retired_count} !== {16'hBEEF, 3'd3, 1'b1, e.cnt}) begin
      errors++;
      $display("FAIL stall_capture: got d=%h a=%0d we=%b cnt=%h want d=beef a=3 we=1 cnt=%h",
               dWB, writeAddrWB, writeEnableWB, retired_count, e.cnt);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 16'($urandom), 3'($urandom), 1'b1);
      e = sb.pop_front();
      checks++;
      if ({dWB, writeAddrWB, writeEnableWB, retired_count} !== {16'hBEEF, 3'd3, 1'b0, cnt0 + 16'd1} ||
          {dWB, writeAddrWB, writeEnableWB, retired_count} !== {e.data, e.addr, e.we, e.cnt}) begin
        errors++;
        $display("FAIL stall_hold%0d: got d=%h a=%0d we=%b cnt=%h want d=beef a=3 we=0 cnt=%h",
                 k, dWB, writeAddrWB, writeEnableWB, retired_count, cnt0 + 16'd1);
      end
    end
  endtask

  task automatic test_forward();
    srcA_addr = 3'd2;
    srcB_addr = 3'd2;
    drive(1'b0, 1'b1, 16'h00AA, 3'd2, 1'b1);
    e = sb.pop_front();
    checks++;
    if ({dWB, writeAddrWB, writeEnableWB} !== {16'h00AA, 3'd2, 1'b1} ||
        {dWB, writeAddrWB, writeEnableWB, retired_count} !== {e.data, e.addr, e.we, e.cnt}) begin
      errors++;
      $display("FAIL fwd_wbout: got d=%h a=%0d we=%b cnt=%h want d=00aa a=2 we=1 cnt=%h",
               dWB, writeAddrWB, writeEnableWB, retired_count, e.cnt);
    end
    checks++;
    if ({fwdA_hit, fwdB_hit, fwd_data} !== {FWD, FWD, (FWD ? 16'h00AA : 16'h0)}) begin
      errors++;
      $display("FAIL fwd_both: got hA=%b hB=%b fd=%h want hA=%b hB=%b fd=%h",
               fwdA_hit, fwdB_hit, fwd_data, FWD, FWD, (FWD ? 16'h00AA : 16'h0));
    end
    srcB_addr = 3'd4;
    #1;
    checks++;
    if ({fwdA_hit, fwdB_hit} !== {FWD, 1'b0}) begin
      errors++;
      $display("FAIL fwd_b_miss: got hA=%b hB=%b want hA=%b hB=0", fwdA_hit, fwdB_hit, FWD);
    end
    srcB_addr = 3'd2;
    drive(1'b0, 1'b1, 16'h00AA, 3'd2, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({fwdA_hit, fwdB_hit, writeEnableWB} !== 3'b000 ||
        {dWB, writeAddrWB, writeEnableWB, retired_count} !== {e.data, e.addr, e.we, e.cnt}) begin
      errors++;
      $display("FAIL fwd_nowe: got hA=%b hB=%b we=%b cnt=%h want 0 0 0 cnt=%h",
               fwdA_hit, fwdB_hit, writeEnableWB, retired_count, e.cnt);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want [3];
    bit reached = 1'b0;
    want[0] = 16'hFFFF; want[1] = 16'h0000; want[2] = 16'h0001;
    for (int i = 0; i < 70000 && !reached; i++) begin
      drive(1'b0, 1'b1, 16'(i), 3'(i), 1'b1);
      e = sb.pop_front();
      if (e.cnt == 16'hFFFE) reached = 1'b1;
    end
    checks++;
    if (!reached || retired_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL wrap_preload: got cnt=%h want cnt=fffe", retired_count);
    end
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 1'b1, 16'hA000 + 16'(j), 3'(j), 1'b1);
      e = sb.pop_front();
      checks++;
      if (retired_count !== want[j] ||
          {dWB, writeAddrWB, writeEnableWB, retired_count} !== {e.data, e.addr, e.we, e.cnt}) begin
        errors++;
        $display("FAIL wrap_seq%0d: got d=%h we=%b cnt=%h want d=%h we=%b cnt=%h",
                 j, dWB, writeEnableWB, retired_count, e.data, e.we, want[j]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b0, 1'b1, 16'h1111, 3'd1, 1'b1);
    e = sb.pop_front();
    drive(1'b1, 1'b1, 16'h5555, 3'd7, 1'b1);
    e = sb.pop_front();
    checks++;
    if ({dWB, writeAddrWB, writeEnableWB, retired_count} !== {16'h0, 3'd0, 1'b0, 16'h0} ||
        {dWB, writeAddrWB, writeEnableWB, retired_count} !== {e.data, e.addr, e.we, e.cnt}) begin
      errors++;
      $display("FAIL reset_mid: got d=%h a=%0d we=%b cnt=%h want d=0 a=0 we=0 cnt=0",
               dWB, writeAddrWB, writeEnableWB, retired_count);
    end
    drive(1'b0, 1'b0, 16'h0, 3'd0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (retired_count !== 16'h0 || writeEnableWB !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop: got we=%b cnt=%h want we=0 cnt=0", writeEnableWB, retired_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic [2:0]  a;
    logic        w;
    for (int i = 0; i < 8; i++) begin
      d = 16'($urandom);
      a = 3'($urandom);
      w = 1'($urandom);
      drive(1'b0, 1'b1, d, a, w);
      e = sb.pop_front();
      checks++;
      if ({dWB, writeAddrWB, writeEnableWB} !== {d, a, w} ||
          {dWB, writeAddrWB, writeEnableWB, retired_count} !== {e.data, e.addr, e.we, e.cnt}) begin
        errors++;
        $display("FAIL b2b%0d: got d=%h a=%0d we=%b cnt=%h want d=%h a=%0d we=%b cnt=%h",
                 i, dWB, writeAddrWB, writeEnableWB, retired_count, d, a, w, e.cnt);
      end
    end
  endtask

  initial begin
    srcA_addr = 3'd0;
    srcB_addr = 3'd0;
    test_reset();
    test_basic();
    test_stall();
    test_forward();
    test_back_to_back();
    test_reset_midstream();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
